// File: rtl/traffic_phase_ctrl_if.sv
// Sensor and lamp signals of one intersection controller, grouped as a bundle.
// The controller is the slave: it samples sensors and drives lamps/status.
interface traffic_phase_ctrl_if #(
  parameter int N_PHASES = 4
);
  logic [N_PHASES-1:0]   x;
  logic [2*N_PHASES-1:0] lights;
  logic [2:0]            phase;
  logic [1:0]            state;

  modport master (output x, input lights, phase, state);
  modport slave  (input x, output lights, phase, state);
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Round-robin multi-approach signal controller: latched requests, min/max green,
// yellow and all-red clearance, rest-in-green when nobody else is waiting.
module traffic_phase_ctrl #(
  parameter int N_PHASES  = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic clear,
  traffic_phase_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } fsm_e;

  localparam logic [1:0]       LAMP_RED    = 2'd0;
  localparam logic [1:0]       LAMP_YELLOW = 2'd1;
  localparam logic [1:0]       LAMP_GREEN  = 2'd2;
  localparam logic [CNT_W-1:0] GMIN_LAST   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST   = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST     = CNT_W'(ALLRED_T - 1);

  fsm_e                state_q, state_d;
  logic [2:0]          p_q, p_d;
  logic [CNT_W-1:0]    t_q, t_d;
  logic [N_PHASES-1:0] req_q, req_d;

  logic                p_legal;
  logic [N_PHASES-1:0] p_onehot;
  logic                other_demand;
  logic                own_sensor;
  logic                grant_found;
  logic [2:0]          grant_idx;
  logic [2*N_PHASES-1:0] lights_w;
  logic [1:0]          lamp_code;

  assign p_legal      = int'(p_q) < N_PHASES;
  assign p_onehot     = p_legal ? (N_PHASES'(1) << p_q) : '0;
  assign other_demand = |(req_q & ~p_onehot);
  assign own_sensor   = |(bus.x & p_onehot);

  // Search p+1, p+2, ... p+N; descending k lets the nearest pending index win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = p_q;
    for (int k = N_PHASES; k >= 1; k--) begin
      if (req_q[(int'(p_q) + k) % N_PHASES]) begin
        grant_found = 1'b1;
        grant_idx   = 3'((int'(p_q) + k) % N_PHASES);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    state_d = state_q;
    p_d     = p_q;
    t_d     = (t_q == '1) ? t_q : t_q + CNT_W'(1);
    req_d   = req_q | bus.x;

    case (state_q)
      GREEN: begin
        req_d = req_d & ~p_onehot;
        if (other_demand && t_q >= GMIN_LAST && (!own_sensor || t_q >= GMAX_LAST)) begin
          state_d = YELLOW;
          t_d     = '0;
        end else if (t_q >= GMAX_LAST) begin
          t_d = GMAX_LAST;
        end
      end
      YELLOW: begin
        if (t_q >= YEL_LAST) begin
          state_d = ALLRED;
          t_d     = '0;
        end
      end
      ALLRED: begin
        if (t_q >= AR_LAST) begin
          state_d = GREEN;
          t_d     = '0;
          if (grant_found) begin
            p_d   = grant_idx;
            req_d = req_d & ~(N_PHASES'(1) << grant_idx);
          end
        end
      end
      default: begin
        state_d = GREEN;
        p_d     = '0;
        t_d     = '0;
      end
    endcase

    if (!p_legal) begin
      state_d = GREEN;
      p_d     = '0;
      t_d     = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; clear acts without a clock.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= GREEN;
      p_q     <= '0;
      t_q     <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      t_q     <= t_d;
      req_q   <= req_d;
    end
  end

  // Lamps decode from registered state only, so sensors never reach outputs directly.
  always_comb begin
    lights_w  = '0;
    lamp_code = LAMP_RED;
    if (state_q == GREEN)  lamp_code = LAMP_GREEN;
    if (state_q == YELLOW) lamp_code = LAMP_YELLOW;
    for (int i = 0; i < N_PHASES; i++) begin
      if (p_legal && p_q == 3'(i)) lights_w[2*i +: 2] = lamp_code;
    end
  end

  assign bus.lights = lights_w;
  assign bus.phase  = p_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed scenarios plus random sensor traffic against a cycle-level model of
// the controller rules; every cycle compares lamps, phase and state.
module tb_traffic_phase_ctrl;
  localparam int N    = 4;
  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 3;
  localparam int ART  = 2;

  logic clk = 1'b0;
  logic clear;

  traffic_phase_ctrl_if #(.N_PHASES(N)) bus ();

  traffic_phase_ctrl #(
    .N_PHASES(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALLRED_T(ART), .CNT_W(8)
  ) dut (
    .clk  (clk),
    .clear(clear),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: signal aspect, serving approach, cycles spent in the aspect,
  // and the set of approaches that have asked for service.
  int         m_st;
  int         m_p;
  int         m_age;
  bit [N-1:0] m_req;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_p   = 0;
    m_age = 0;
    m_req = '0;
  endtask

  task automatic model_step(input bit [N-1:0] xv);
    int         nst   = m_st;
    int         np    = m_p;
    int         nage  = m_age + 1;
    bit [N-1:0] nreq  = m_req | xv;
    bit         waiting = 1'b0;
    bit         found   = 1'b0;
    for (int i = 0; i < N; i++) if (i != m_p && m_req[i]) waiting = 1'b1;
    if (m_st == 0) begin
      nreq[m_p] = 1'b0;
      if (waiting && nage >= GMIN && (!xv[m_p] || nage >= GMAX)) begin
        nst = 1; nage = 0;
      end else if (nage > GMAX - 1) begin
        nage = GMAX - 1;
      end
    end else if (m_st == 1) begin
      if (nage == YT) begin nst = 2; nage = 0; end
    end else begin
      if (nage == ART) begin
        nst = 0; nage = 0;
        for (int k = 1; k <= N && !found; k++) begin
          if (m_req[(m_p + k) % N]) begin
            found = 1'b1;
            np    = (m_p + k) % N;
          end
        end
        if (found) nreq[np] = 1'b0;
      end
    end
    m_st = nst; m_p = np; m_age = nage; m_req = nreq;
  endtask

  function automatic logic [2*N-1:0] exp_lights();
    logic [2*N-1:0] l = '0;
    if (m_st == 0) l[2*m_p +: 2] = 2'd2;
    if (m_st == 1) l[2*m_p +: 2] = 2'd1;
    return l;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".lights"}, 32'(bus.lights), 32'(exp_lights()));
    check({tag, ".phase"},  32'(bus.phase),  m_p);
    check({tag, ".state"},  32'(bus.state),  m_st);
  endtask

  task automatic cycle(input bit [N-1:0] xv);
    bus.x = xv;
    @(posedge clk);
    model_step(xv);
    #1;
    check_outputs("cyc");
  endtask

  task automatic wait_for(input int st, input int ph, input bit [N-1:0] xv,
                          input int budget, input string tag);
    int n = 0;
    while (!(bus.state === 2'(st) && bus.phase === 3'(ph)) && n < budget) begin
      cycle(xv);
      n++;
    end
    check({tag, ".reached"}, 32'(bus.state === 2'(st) && bus.phase === 3'(ph)), 1);
  endtask

  int         order[$];
  int         last_green;
  bit         lit0;
  int         n;
  bit [N-1:0] xr;

  initial begin
    clear = 1'b1;
    bus.x = '0;
    model_reset();
    #2;
    check("reset.lights", 32'(bus.lights), 32'h02);
    check("reset.phase",  32'(bus.phase),  0);
    check("reset.state",  32'(bus.state),  0);
    #5 clear = 1'b0;

    // Rest in green, then serve approach 2 after a one-cycle pulse.
    for (int i = 0; i < 20; i++) begin
      cycle('0);
      check("rest.state", 32'(bus.state), 0);
    end
    cycle(4'b0100);
    cycle('0);
    check("serve.yellow_e1", 32'(bus.state), 1);
    cycle('0); cycle('0); cycle('0);
    check("serve.allred_e4", 32'(bus.state), 2);
    cycle('0); cycle('0);
    check("serve.green_e6.state",  32'(bus.state),  0);
    check("serve.green_e6.lights", 32'(bus.lights), 32'h20);

    // Round-robin from 2 with demand on 1 and 3: 3 first, then 1, never 0.
    cycle(4'b1010);
    order.delete();
    last_green = 2;
    lit0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle('0);
      if (bus.lights[1:0] != 2'd0) lit0 = 1'b1;
      if (bus.state == 2'd0 && int'(bus.phase) != last_green) begin
        last_green = int'(bus.phase);
        order.push_back(last_green);
      end
    end
    check("rr.count",  order.size(), 2);
    check("rr.first",  (order.size() > 0) ? order[0] : 99, 3);
    check("rr.second", (order.size() > 1) ? order[1] : 99, 1);
    check("rr.no_phase0", 32'(lit0), 0);

    // Approach 2 asks again during its own yellow: served after approach 0.
    cycle(4'b0100);
    wait_for(0, 2, '0, 30, "self.to2");
    cycle(4'b0001);
    wait_for(1, 2, '0, 30, "self.yellow2");
    cycle(4'b0100);
    order.delete();
    last_green = 2;
    for (int i = 0; i < 40; i++) begin
      cycle('0);
      if (bus.state == 2'd0 && int'(bus.phase) != last_green) begin
        last_green = int'(bus.phase);
        order.push_back(last_green);
      end
    end
    check("self.count",  order.size(), 2);
    check("self.first",  (order.size() > 0) ? order[0] : 99, 0);
    check("self.second", (order.size() > 1) ? order[1] : 99, 2);
    check("self.rest",   32'(bus.state), 0);

    // Clear between edges in all-red, then minimum green with x[1] held.
    cycle(4'b1000);
    wait_for(2, 2, '0, 30, "rst.allred");
    #3 clear = 1'b1;
    #1;
    model_reset();
    check("rst.now.lights", 32'(bus.lights), 32'h02);
    check("rst.now.phase",  32'(bus.phase),  0);
    check("rst.now.state",  32'(bus.state),  0);
    bus.x = 4'b0010;
    #2 clear = 1'b0;
    cycle(4'b0010); cycle(4'b0010); cycle(4'b0010);
    check("min.green_e3", 32'(bus.state), 0);
    cycle(4'b0010);
    check("min.yellow_e4", 32'(bus.state), 1);
    cycle(4'b0010); cycle(4'b0010);
    check("min.yellow_e6", 32'(bus.state), 1);
    cycle(4'b0010);
    check("min.allred_e7", 32'(bus.state), 2);
    cycle(4'b0010);
    check("min.allred_e8", 32'(bus.state), 2);
    cycle(4'b0010);
    check("min.green1_e9.state", 32'(bus.state), 0);
    check("min.green1_e9.phase", 32'(bus.phase), 1);

    // Extension to GREEN_MAX: x[0] held while approach 3 waits.
    wait_for(0, 0, 4'b0001, 40, "ext.to0");
    cycle(4'b1001);
    n = 1;
    while (bus.state == 2'd0 && n < 30) begin
      cycle(4'b0001);
      n++;
    end
    check("ext.green_len", n, GMAX);

    // Random sensor traffic with one asynchronous clear in the middle.
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) xr[b] = ($urandom_range(0, 7) == 0);
      cycle(xr);
      if (i == 200) begin
        #2 clear = 1'b1;
        #1;
        model_reset();
        check_outputs("rnd.clear");
        #1 clear = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised multi-approach traffic signal controller generalising the two-road highway/country controller to N_PHASES approaches. It has per-approach vehicle sensing, latched requests, and programmable green-minimum, green-maximum, yellow and all-red durations counted in clock cycles. It serves phases round-robin, skips approaches with no demand and rests in green when no other approach is waiting. It sits at intersection level and drives the lamp decoders directly.

## Interface

- N_PHASES, 4, number of approaches; legal range 2..8
- GREEN_MIN, 4, minimum green duration in cycles; must be ≥1
- GREEN_MAX, 10, maximum green when the own sensor keeps extending; must be ≥ GREEN_MIN
- YELLOW_T, 3, yellow duration in cycles; must be ≥1
- ALLRED_T, 2, all-red clearance in cycles; must be ≥1
- CNT_W, 8, phase timer width; must hold max(GREEN_MAX, YELLOW_T, ALLRED_T)
- clk  in  1  single clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- x  in  N_PHASES  vehicle sensors, one bit per approach, sampled on clk
- lights  out  2*N_PHASES  lamp code per approach at bits [2i+1:2i]; red=2'd0, yellow=2'd1, green=2'd2; 2'd3 is never driven
- phase  out  3  index of the approach currently holding right-of-way
- state  out  2  GREEN=0, YELLOW=1, ALLRED=2; 3 is unused

## Operation

- Internal registers:
  - fsm state
  - current phase p
  - timer t (cycles elapsed in the current state, 0 on the first cycle, saturates)
  - request vector req[N_PHASES-1:0]
- Request latch, each edge:
  - req[i] <= req[i] | x[i] for every i.
  - Exception: i == p while in GREEN, where req[p] is held at 0 because the approach is being served.
  - A phase's req bit clears on the edge it enters GREEN.
- Other demand: D = |(req & ~onehot(p)). D is computed from the registered req, so a sensor pulse affects control one edge later.
- GREEN:
  - lights[p] = green; all other approaches red.
  - Go to YELLOW when D && t ≥ GREEN_MIN-1 && (!x[p] || t ≥ GREEN_MAX-1).
  - If D is 0, stay green indefinitely (rest-in-green); t saturates at GREEN_MAX-1.
- YELLOW:
  - lights[p] = yellow; all others red.
  - After YELLOW_T cycles go to ALLRED.
- ALLRED:
  - All approaches red.
  - After ALLRED_T cycles go to GREEN with p <= first index j in the order p+1, p+2, … (mod N_PHASES) with req[j] = 1.
- Next-phase guarantee: req bits are only cleared on grant, so a pending non-current request always exists at this point. If none exists (illegal state), p is held and the fsm returns to GREEN.
- Sensor behaviour in YELLOW and ALLRED: x[p] latches into req[p] normally. Phase p is then served again after the others in round-robin order.
- Illegal encodings:
  - fsm code 3 or p ≥ N_PHASES recovers to GREEN, p = 0 on the next edge.
  - lights decode treats any illegal state as all red.
- Simultaneous events: a request arriving on the same edge as a grant to that phase is absorbed by the grant (the bit is cleared).

## Timing

- Reset values, immediate on clear asserting, independent of clk:
  - state = GREEN, phase = 0, t = 0, req = 0
  - lights = approach 0 green, all others red
- Reset asserted mid-YELLOW or mid-ALLRED behaves the same: outputs jump to reset values at once, and pending requests are lost.
- First rising edge after clear deasserts is timer cycle t = 1 of GREEN phase 0.
- lights, phase and state are registered. They change only on the clk edge that changes the fsm, with no combinational path from x to any output.
- Request-to-yellow latency from resting green: x[j] high at edge E sets req[j] at E; YELLOW is entered at E+1.
- Transition edges after entering YELLOW at edge Y:
  - ALLRED at Y+YELLOW_T
  - GREEN at Y+YELLOW_T+ALLRED_T
- Green duration with continuous other demand:
  - GREEN_MIN cycles when x[p] = 0
  - GREEN_MAX cycles when x[p] is held at 1

## Test plan

- Reset: assert clear between edges mid-ALLRED. Required: outputs show state=0, phase=0, lights=8'b00000010 without waiting for a clk edge, and phase 0 is served after release.
- Rest and serve, defaults: 20 idle cycles, then x[2] pulsed for one cycle, sampled at edge E. Required: green holds throughout the idle period; YELLOW from E+1, ALLRED from E+4, phase=2 GREEN (lights=8'b00100000) from E+6.
- Minimum green: x[1] held high from the first edge after reset. Required: phase 0 green for exactly 4 cycles, then yellow for 3, all-red for 2, then phase 1 green.
- Extension and max: in phase 0 green, x[0] held high and x[3] pulsed. Required: phase 0 green lasts exactly 10 cycles from entry before yellow.
- Round-robin and skip: phase 2 green; x[1] and x[3] pulsed on the same edge. Required: phase 3 is served next, then phase 1; phase 0 is never lit.
- Self re-request: x[2] pulsed during phase 2 YELLOW with no other demand. Required: after ALLRED, phase 2 returns to GREEN and req is all zero.
